// File: rtl/maj_vote_arbiter.sv
// Round-robin arbiter feeding a shared 2-of-3 bitwise majority voter.
// One registered result slot with a valid/ready handshake toward the consumer.
module maj_vote_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ*WIDTH-1:0] c_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_y,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_disagree,
  output logic [7:0]            err_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             dis_q, dis_d;
  logic [7:0]       err_q, err_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] maj_w [NREQ];
  logic             dis_w [NREQ];

  logic             found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W:0]    cand;
  logic [ID_W:0]    ptr_inc;
  logic             can_accept;
  logic             grant;

  // Per-requester voters; only the granted lane is registered.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      logic [WIDTH-1:0] a_w, b_w, c_w;
      assign a_w       = a_in[gi*WIDTH +: WIDTH];
      assign b_w       = b_in[gi*WIDTH +: WIDTH];
      assign c_w       = c_in[gi*WIDTH +: WIDTH];
      assign maj_w[gi] = (a_w & b_w) | (b_w & c_w) | (c_w & a_w);
      assign dis_w[gi] = |((a_w ^ b_w) | (b_w ^ c_w));
    end
  endgenerate

  // Rotating search from ptr_q upward, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && req[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[ID_W-1:0];
      end
    end
    ptr_inc = {1'b0, win_idx} + {{ID_W{1'b0}}, 1'b1};
    if (ptr_inc >= NREQ_W) begin
      ptr_inc = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    id_d       = id_q;
    dis_d      = dis_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    gnt        = '0;
    can_accept = (state_q == EMPTY) | out_ready;
    grant      = can_accept & found & rst_n;

    if (grant) begin
      gnt[win_idx] = 1'b1;
      state_d      = FULL;
      y_d          = maj_w[win_idx];
      id_d         = win_idx;
      dis_d        = dis_w[win_idx];
      ptr_d        = ptr_inc[ID_W-1:0];
      if (dis_w[win_idx] && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      id_q    <= '0;
      dis_q   <= 1'b0;
      err_q   <= 8'd0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      id_q    <= id_d;
      dis_q   <= dis_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid    = (state_q == FULL);
  assign out_y        = y_q;
  assign out_id       = id_q;
  assign out_disagree = dis_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_maj_vote_arbiter.sv
// Directed bench for maj_vote_arbiter (NREQ=4, WIDTH=4) with hand-computed expectations.
module tb_maj_vote_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] a_in, b_in, c_in;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_y;
  logic [1:0]  out_id;
  logic        out_disagree;
  logic [7:0]  err_count;

  int n_asserts = 0;
  int n_fail    = 0;

  maj_vote_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .c_in         (c_in),
    .gnt          (gnt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_id       (out_id),
    .out_disagree (out_disagree),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_gnt [8];
  logic [1:0] rot_id  [8];
  logic [3:0] rot_y   [8];

  initial begin
    rot_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_id  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rot_y   = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    // Reset: requests and ready are active, yet nothing may be granted.
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    a_in = '0; b_in = '0; c_in = '0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y",     32'(out_y),     32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_err",   32'(err_count), 32'd0);
    chk("rst_gnt",   32'(gnt),       32'd0);
    #5;
    rst_n = 1'b1;

    // Single requester with a disagreeing triple.
    req = 4'b0001; a_in = 16'h000C; b_in = 16'h000A; c_in = 16'h0006;
    #1;
    chk("single_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("single_valid", 32'(out_valid),    32'd1);
    chk("single_y",     32'(out_y),        32'b1110);
    chk("single_id",    32'(out_id),       32'd0);
    chk("single_dis",   32'(out_disagree), 32'd1);
    chk("single_err",   32'(err_count),    32'd1);

    // Drain with no new request: slot empties, data holds.
    req = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_y",     32'(out_y),     32'b1110);

    // Round robin with all requesting; pointer is 1 after the first grant.
    req = 4'b1111; a_in = 16'h8421; b_in = 16'h8421; c_in = 16'h8421;
    for (int s = 0; s < 8; s++) begin
      #1;
      chk($sformatf("rot_gnt%0d", s), 32'(gnt), 32'(rot_gnt[s]));
      tick();
      chk($sformatf("rot_id%0d", s),  32'(out_id),       32'(rot_id[s]));
      chk($sformatf("rot_y%0d", s),   32'(out_y),        32'(rot_y[s]));
      chk($sformatf("rot_dis%0d", s), 32'(out_disagree), 32'd0);
    end
    chk("rot_err", 32'(err_count), 32'd1);

    // Backpressure: FULL holding id 0, ptr now 1.
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("bp_gnt%0d", s), 32'(gnt), 32'd0);
      tick();
      chk($sformatf("bp_valid%0d", s), 32'(out_valid), 32'd1);
      chk($sformatf("bp_id%0d", s),    32'(out_id),    32'd0);
      chk($sformatf("bp_y%0d", s),     32'(out_y),     32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("bp_release_id", 32'(out_id), 32'd1);
    chk("bp_release_y",  32'(out_y),  32'h2);

    // Pointer wrap: ptr=2, req=1001 -> 3 then 0.
    req = 4'b1001;
    #1;
    chk("wrap_gnt3", 32'(gnt), 32'b1000);
    tick();
    chk("wrap_id3", 32'(out_id), 32'd3);
    #1;
    chk("wrap_gnt0", 32'(gnt), 32'b0001);
    tick();
    chk("wrap_id0", 32'(out_id), 32'd0);

    // Saturation: each accepted triple disagrees on bit 0; err starts at 1.
    req = 4'b1111; a_in = 16'h1111; b_in = 16'h0000; c_in = 16'h0000;
    for (int s = 0; s < 300; s++) begin
      tick();
      if (s == 99) chk("sat_err100", 32'(err_count), 32'd101);
      if (s == 253) chk("sat_err_hit", 32'(err_count), 32'd255);
    end
    chk("sat_err_end", 32'(err_count),    32'd255);
    chk("sat_y",       32'(out_y),        32'h0);
    chk("sat_dis",     32'(out_disagree), 32'd1);

    // Asynchronous reset mid-cycle while FULL.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_y",     32'(out_y),     32'd0);
    chk("arst_id",    32'(out_id),    32'd0);
    chk("arst_err",   32'(err_count), 32'd0);
    chk("arst_gnt",   32'(gnt),       32'd0);
    a_in = '0; b_in = '0; c_in = '0; req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_id",    32'(out_id),    32'd1);
    chk("post_rst_err",   32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
